// File: rtl/fetch_stage_if.sv
// Instruction-side SRAM-like request channel between the fetch stage and
// instruction memory.
//   inst_req      fetch -> mem   request valid
//   inst_addr     fetch -> mem   request address, stable while inst_req held
//   inst_addr_ok  mem -> fetch   request accepted this cycle
interface fetch_stage_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage feeding decode. Owns the fetch PC, issues one instruction
// request at a time, and keeps a single fetch slot (valid/pc/cancel/exc)
// whose data decode takes directly from the memory return path.
//   clk, resetn        clock and asynchronous active-low reset
//   inst               instruction request channel (master side)
//   ready_i, done_i    decode advances / decode finished with the slot
//   redirect_valid/pc  kill slot and younger fetches, restart at redirect_pc
//   valid_o, pc_o      slot occupancy and PC
//   cancelled_o        slot killed; decode drains and drops it
//   exc_o, exccode_o   slot carries a fetch address error (AdEL = 5'h04)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic                 clk,
    input  logic                 resetn,
    fetch_stage_if.master        inst,
    input  logic                 ready_i,
    input  logic                 done_i,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 valid_o,
    output logic [31:0]          pc_o,
    output logic                 cancelled_o,
    output logic                 exc_o,
    output logic [4:0]           exccode_o
);
    localparam logic [4:0] EXC_ADEL = 5'h04;

    typedef enum logic [1:0] {RUN, HOLD, HALT} state_t;

    state_t      state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic        redir_pend_reg, redir_pend_next;
    logic [31:0] redir_pc_q_reg, redir_pc_q_next;
    logic        valid_reg, valid_next;
    logic [31:0] pc_reg, pc_next;
    logic        cancelled_reg, cancelled_next;
    logic        exc_reg, exc_next;
    logic [4:0]  exccode_reg, exccode_next;

    logic slot_release;
    logic slot_free;
    logic req_int;
    logic fetch_load;
    logic exc_load;

    assign slot_release = valid_reg & ready_i & done_i;
    assign slot_free    = ~valid_reg | slot_release;

    // While reset is held the request is forced low so that an in-flight
    // handshake is withdrawn the instant reset asserts.
    assign inst.inst_req  = req_int & resetn;
    // The address is always the fetch PC: it is not advanced or redirected
    // until the outstanding request is accepted, so it stays stable in HOLD.
    assign inst.inst_addr = fetch_pc_reg;

    assign valid_o     = valid_reg;
    assign pc_o        = pc_reg;
    assign cancelled_o = cancelled_reg;
    assign exc_o       = exc_reg;
    assign exccode_o   = exccode_reg;

    always_comb begin
        state_next      = state_reg;
        fetch_pc_next   = fetch_pc_reg;
        redir_pend_next = redir_pend_reg;
        redir_pc_q_next = redir_pc_q_reg;
        valid_next      = valid_reg;
        pc_next         = pc_reg;
        cancelled_next  = cancelled_reg;
        exc_next        = exc_reg;
        exccode_next    = exccode_reg;
        req_int         = 1'b0;
        exc_load        = 1'b0;
        fetch_load      = 1'b0;

        unique case (state_reg)
            RUN: begin
                if (slot_free) begin
                    if (fetch_pc_reg[1:0] == 2'b00) begin
                        req_int = 1'b1;
                    end else if (!redirect_valid) begin
                        // A simultaneous redirect makes the bad PC dead,
                        // so the exception is only raised without one.
                        exc_load   = 1'b1;
                        state_next = HALT;
                    end
                end
            end
            HOLD: req_int = 1'b1;
            default: ;
        endcase

        if (req_int) begin
            if (inst.inst_addr_ok) begin
                fetch_load      = 1'b1;
                state_next      = RUN;
                redir_pend_next = 1'b0;
                if (redirect_valid)
                    fetch_pc_next = redirect_pc;
                else if (redir_pend_reg)
                    fetch_pc_next = redir_pc_q_reg;
                else
                    fetch_pc_next = fetch_pc_reg + 32'd4;
            end else begin
                state_next = HOLD;
                // The held request is now dead; remember where to restart.
                // A later redirect simply overwrites the target.
                if (redirect_valid) begin
                    redir_pend_next = 1'b1;
                    redir_pc_q_next = redirect_pc;
                end
            end
        end else if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
            state_next    = RUN;
        end

        if (slot_release) begin
            valid_next     = 1'b0;
            cancelled_next = 1'b0;
            exc_next       = 1'b0;
            exccode_next   = 5'h00;
        end else if (redirect_valid && valid_reg) begin
            cancelled_next = 1'b1;
        end

        if (fetch_load) begin
            valid_next     = 1'b1;
            pc_next        = fetch_pc_reg;
            cancelled_next = redir_pend_reg | redirect_valid;
            exc_next       = 1'b0;
            exccode_next   = 5'h00;
        end else if (exc_load) begin
            valid_next     = 1'b1;
            pc_next        = fetch_pc_reg;
            cancelled_next = 1'b0;
            exc_next       = 1'b1;
            exccode_next   = EXC_ADEL;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= RUN;
            fetch_pc_reg   <= RESET_PC;
            redir_pend_reg <= 1'b0;
            redir_pc_q_reg <= 32'h0;
            valid_reg      <= 1'b0;
            pc_reg         <= 32'h0;
            cancelled_reg  <= 1'b0;
            exc_reg        <= 1'b0;
            exccode_reg    <= 5'h00;
        end else begin
            state_reg      <= state_next;
            fetch_pc_reg   <= fetch_pc_next;
            redir_pend_reg <= redir_pend_next;
            redir_pc_q_reg <= redir_pc_q_next;
            valid_reg      <= valid_next;
            pc_reg         <= pc_next;
            cancelled_reg  <= cancelled_next;
            exc_reg        <= exc_next;
            exccode_reg    <= exccode_next;
        end
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Fetch stage directly upstream of the decode stage. It owns the fetch PC, issues instruction requests on the instruction-side SRAM-like interface, and keeps one fetch slot (`valid_o`/`pc_o`) whose instruction data decode consumes straight from `inst_rdata`/`inst_data_ok`. The stage handles redirects from branches and exceptions, cancels in-flight fetches, and raises instruction-fetch address errors.

## Interface
- `RESET_PC`, default 32'hBFC00000: first fetch address after reset.
- `clk`  in  1  clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `inst_req`  out  1  instruction request valid.
- `inst_addr`  out  32  request address; stable while `inst_req` is held.
- `inst_addr_ok`  in  1  request accepted this cycle.
- `ready_i`  in  1  decode pipeline advances this cycle.
- `done_i`  in  1  decode has finished with the current slot (decode `done_o`).
- `redirect_valid`  in  1  one-cycle pulse: kill the slot and all younger fetches, then restart at `redirect_pc`.
- `redirect_pc`  in  32  restart address.
- `valid_o`  out  1  slot holds a requested instruction or an exception.
- `pc_o`  out  32  PC of the slot.
- `cancelled_o`  out  1  slot is killed; decode drains its data and drops it.
- `exc_o`  out  1  slot carries a fetch exception.
- `exccode_o`  out  5  exception code (5'h04 AdEL).

## Operation
- `release = valid_o & ready_i & done_i`. `slot_free = !valid_o | release`.
- Registered state: `fetch_pc`, `hold`, `redir_pend`, `redir_pc_q`, plus FSM states RUN, HOLD, HALT.
- RUN: when `slot_free` and `fetch_pc[1:0]==0`, drive `inst_req=1` and `inst_addr=fetch_pc`.
  - If `inst_addr_ok` is seen: on the next edge load the slot with `valid_o=1`, `pc_o=fetch_pc`, `cancelled_o=0`, `exc_o=0`, and set `fetch_pc += 4` (mod 2^32).
  - If `inst_addr_ok` is not seen: go to HOLD.
- HOLD: `inst_req=1` and `inst_addr` stay locked to the pending address regardless of redirects. On `inst_addr_ok`, load the slot as above and return to RUN.
- Misaligned `fetch_pc` with `slot_free`: issue no request. Load the slot with `valid_o=1`, `pc_o=fetch_pc`, `exc_o=1`, `exccode_o=5'h04`. Go to HALT.
- HALT: no requests until a redirect arrives.
- Slot release with no new load: `valid_o <= 0`. Other slot fields are don't-care while `valid_o=0`.
- `redirect_valid`:
  - If the slot is occupied and not releasing: `cancelled_o <= 1`, sticky until release.
  - A request that was asserted in the redirect cycle, or is still held, is cancelled whenever it is accepted: the slot loads with `cancelled_o=1`. `redir_pend` keeps `redir_pc_q`. After that request is accepted, `fetch_pc <= redir_pc_q`.
  - If no request is outstanding: `fetch_pc <= redirect_pc` directly.
  - HALT → RUN.
  - A later redirect overrides a pending one.
- Producer rule: a branch asserts `redirect_valid` only after its delay slot has left the fetch slot.
- One request at most in flight beyond the slot. The next request is issued only when the slot frees, which guarantees decode never sees two data returns for one slot.

## Timing
- Reset (async, held): `inst_req=0`, `valid_o=0`, `pc_o=0`, `cancelled_o=0`, `exc_o=0`, `exccode_o=0`, `fetch_pc=RESET_PC`, state RUN, `redir_pend=0`.
- First request goes out in the first cycle after `resetn` rises.
- `inst_req`/`inst_addr` are combinational from state and `release`. No path exists from `inst_addr_ok` to `inst_req`.
- Throughput: 1 instr/cycle when `inst_addr_ok` coincides with `release`. Each cycle `inst_addr_ok` is withheld adds one bubble cycle.
- Redirect to the first request at `redirect_pc`: next cycle if idle; otherwise one cycle after the held request is accepted.
- Reset asserted mid-handshake: everything is dropped immediately. The memory side must tolerate a withdrawn request.

## Test plan
- Reset release, `inst_addr_ok`=1 and `ready_i`=`done_i`=1 every cycle → addresses BFC00000, BFC00004, BFC00008 on consecutive cycles; `pc_o` follows one cycle later.
- `inst_addr_ok` low for 3 cycles on BFC00004 → `inst_req` held 4 cycles, `inst_addr` constant; slot loads once.
- Slot BFC00010 occupied with `ready_i=0`, `redirect_valid` with pc=80001000 → `cancelled_o=1` until release; next request address 80001000.
- Redirect to 80002000 in a cycle where BFC00020 is requested without ack, ack two cycles later → BFC00020 loads with `cancelled_o=1`; next request 80002000.
- Redirect to 80000002 → no `inst_req`; `valid_o=1`, `exc_o=1`, `exccode_o=5'h04`, `pc_o=80000002`; stays in HALT until redirect to 80000000 resumes fetch.
- Assert `resetn` low while a request is held → all outputs go to reset values asynchronously; the restart fetch is BFC00000.
